// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and helpers for the multi-channel clock divider.
//   NCH_DEF      default number of channels
//   W_DEF        default counter/divisor width
//   DIV_RST_DEF  default divisor loaded into every channel at reset
//   div_t        divisor type at the default width
//   ch_idx_w()   width of the channel-index write port (never below 1 bit)
package clkdiv_pkg;

  localparam int unsigned NCH_DEF     = 32'd4;
  localparam int unsigned W_DEF       = 32'd27;
  localparam int unsigned DIV_RST_DEF = 32'd50_000_000;

  typedef logic [W_DEF-1:0] div_t;

  // A single channel still needs a 1-bit index port so the port list stays legal.
  function automatic int unsigned ch_idx_w(input int unsigned nch);
    if (nch <= 32'd1) begin
      return 32'd1;
    end else begin
      return int'($clog2(nch));
    end
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel with shadowed, glitch-free divisor update.
// Ports:
//   clk_in    system clock, all state on its rising edge
//   rst_n     synchronous active-low reset
//   en        run enable for this channel
//   sync_req  force phase realignment (cnt to 0, shadow loaded); tie low if unused
//   wr_stb    divisor write strobe already decoded for this channel
//   wr_div    new divisor value
//   clk_out   registered divided square wave
//   tick      registered one-cycle terminal-count strobe
//   upd_pend  high while a written divisor has not yet become active
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sync_req,
  input  logic         wr_stb,
  input  logic [W-1:0] wr_div,
  output logic         clk_out,
  output logic         tick,
  output logic         upd_pend
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] act_div_q, act_div_d;
  logic [W-1:0] shd_div_q, shd_div_d;
  logic         pend_q, pend_d;
  logic         clk_out_q, clk_out_d;
  logic         tick_q, tick_d;
  logic         reload_s;

  // Next-state: counting, shadow load at terminal count, write capture, phase sync.
  always_comb begin
    cnt_d     = cnt_q;
    act_div_d = act_div_q;
    shd_div_d = shd_div_q;
    pend_d    = pend_q;
    // Reload point: disabled, degenerate divisor (0/1), or last cycle of the period.
    reload_s  = (!en) || (act_div_q <= W'(1)) || (cnt_q >= (act_div_q - W'(1)));
    if (sync_req) begin
      cnt_d     = '0;
      act_div_d = shd_div_q;
      pend_d    = 1'b0;
    end else begin
      if (reload_s) begin
        cnt_d     = '0;
        act_div_d = shd_div_q;
        pend_d    = 1'b0;
      end else begin
        cnt_d     = cnt_q + W'(1);
      end
      // A write on the reload edge lands in the shadow only; the old shadow
      // has already been taken into act_div_d above.
      if (wr_stb) begin
        shd_div_d = wr_div;
        pend_d    = 1'b1;
      end else begin
        shd_div_d = shd_div_q;
      end
    end
  end

  // Output decode from the next cnt/act_div so the flops match the state they sit beside.
  always_comb begin
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    if (en && (act_div_d != '0)) begin
      clk_out_d = (cnt_d >= (act_div_d >> 1));
      tick_d    = (cnt_d == (act_div_d - W'(1)));
    end else begin
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      act_div_q <= W'(DIV_RST);
      shd_div_q <= W'(DIV_RST);
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_div_q <= act_div_d;
      shd_div_q <= shd_div_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign upd_pend = pend_q;

endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NCH independent runtime-programmable clock dividers.
// Optional feature macro: CLKDIV_SYNC_EN adds input sync_req, which realigns
// all channels to cnt=0 (loading any pending divisor) at the next edge.
// Ports:
//   clk_in    system clock
//   rst_n     synchronous active-low reset
//   sync_req  (CLKDIV_SYNC_EN only) global phase realignment request
//   en        per-channel run enable
//   wr_en     divisor write strobe
//   wr_ch     channel index for the write; indices >= NCH are ignored
//   wr_div    new divisor value
//   clk_out   per-channel divided square wave (registered)
//   tick      per-channel terminal-count strobe (registered)
//   upd_pend  per-channel "written divisor not yet active" flag
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned NCH     = NCH_DEF,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned DIV_RST = DIV_RST_DEF,
  localparam int unsigned CH_W   = ch_idx_w(NCH)
) (
  input  logic            clk_in,
  input  logic            rst_n,
`ifdef CLKDIV_SYNC_EN
  input  logic            sync_req,
`endif
  input  logic [NCH-1:0]  en,
  input  logic            wr_en,
  input  logic [CH_W-1:0] wr_ch,
  input  logic [W-1:0]    wr_div,
  output logic [NCH-1:0]  clk_out,
  output logic [NCH-1:0]  tick,
  output logic [NCH-1:0]  upd_pend
);

  logic [NCH-1:0] wr_stb_s;
  logic           sync_s;

`ifdef CLKDIV_SYNC_EN
  assign sync_s = sync_req;
`else
  assign sync_s = 1'b0;
`endif

  // Decode the write index into one strobe per channel; out-of-range indices match nothing.
  always_comb begin
    wr_stb_s = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (wr_en && (wr_ch == CH_W'(i))) begin
        wr_stb_s[i] = 1'b1;
      end else begin
        wr_stb_s[i] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
    clkdiv_channel #(
      .W       (W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .en       (en[g]),
      .sync_req (sync_s),
      .wr_stb   (wr_stb_s[g]),
      .wr_div   (wr_div),
      .clk_out  (clk_out[g]),
      .tick     (tick[g]),
      .upd_pend (upd_pend[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed + randomized bench for clock_divider_multi
// with a behavioural reference model of each channel's period/phase.
module tb_clock_divider_multi;

  localparam int NCH     = 3;
  localparam int W       = 27;
  localparam int DIV_RST = 4;

  logic           clk_in;
  logic           rst_n;
  logic           sync_req;
  logic [NCH-1:0] en;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [W-1:0]   wr_div;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] upd_pend;

  int checks;
  int failures;

  // reference model: position within period, active/shadow divisor, pending flag
  int m_pos  [NCH];
  int m_act  [NCH];
  int m_shd  [NCH];
  bit m_pend [NCH];
  bit e_clk  [NCH];
  bit e_tick [NCH];

  clock_divider_multi #(
    .NCH     (NCH),
    .W       (W),
    .DIV_RST (DIV_RST)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
`ifdef CLKDIV_SYNC_EN
    .sync_req (sync_req),
`endif
    .en       (en),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
    .clk_out  (clk_out),
    .tick     (tick),
    .upd_pend (upd_pend)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Apply one clock edge of the spec rules to the model, using current inputs.
  task automatic model_edge();
    bit do_sync;
    bit run;
    int hi_len;
`ifdef CLKDIV_SYNC_EN
    do_sync = sync_req;
`else
    do_sync = 1'b0;
`endif
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) begin
        m_pos[c] = 0; m_act[c] = DIV_RST; m_shd[c] = DIV_RST; m_pend[c] = 0;
      end else if (do_sync) begin
        m_pos[c] = 0; m_act[c] = m_shd[c]; m_pend[c] = 0;
      end else begin
        if (en[c] && m_act[c] >= 2 && m_pos[c] < m_act[c] - 1) begin
          m_pos[c] = m_pos[c] + 1;
        end else begin
          m_pos[c] = 0; m_act[c] = m_shd[c]; m_pend[c] = 0;
        end
        if (wr_en && int'(wr_ch) == c) begin
          m_shd[c] = int'(wr_div); m_pend[c] = 1;
        end
      end
      run = rst_n && en[c] && (m_act[c] != 0);
      // high during the last ceil(D/2) positions of each D-cycle period
      hi_len = (m_act[c] + 1) / 2;
      e_clk[c]  = run && (m_pos[c] >= m_act[c] - hi_len);
      e_tick[c] = run && (m_pos[c] == m_act[c] - 1);
    end
  endtask

  task automatic chk(input string tag, input int c, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s ch%0d t=%0t: observed %b expected %b", tag, c, $time, got, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    for (int c = 0; c < NCH; c++) begin
      chk("clk_out", c, clk_out[c], e_clk[c]);
      chk("tick", c, tick[c], e_tick[c]);
      chk("upd_pend", c, upd_pend[c], m_pend[c]);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input int ch, input int d);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_div = W'(d);
    step();
    wr_en = 1'b0;
  endtask

  // Advance (bounded) until channel c is running divisor d at position p.
  task automatic wait_state(input int c, input int d, input int p);
    for (int k = 0; k < 64; k++) begin
      if (m_act[c] == d && m_pos[c] == p) break;
      step();
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; sync_req = 1'b0; en = '0;
    wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    for (int c = 0; c < NCH; c++) begin
      m_pos[c] = 0; m_act[c] = DIV_RST; m_shd[c] = DIV_RST; m_pend[c] = 0;
    end

    // reset with a write in the same cycle: write must be dropped
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = W'(7);
    run(2);
    wr_en = 1'b0;

    // default divisor 4 on every channel: 0,0,1,1 and tick every 4th
    rst_n = 1'b1; en = '1;
    run(12);

    // odd divisor on a disabled channel, then enable
    en[1] = 1'b0;
    wr(1, 5);
    run(2);
    en[1] = 1'b1;
    run(15);

    // glitch-free update: ch0 at D=8, write 3 while cnt=2
    wr(0, 8);
    wait_state(0, 8, 2);
    wr(0, 3);
    run(20);

    // D=1 and D=0 on ch2
    wr(2, 1);
    run(6);
    wr(2, 0);
    run(5);
    wr(2, 4);
    run(6);

    // out-of-range channel index
    wr(3, 9);
    run(8);

    // write coincident with terminal count: old shadow applies first
    wr(0, 4);
    wait_state(0, 4, 1);
    wr(0, 6);
    wait_state(0, 4, 3);
    wr(0, 2);
    run(16);

    // reset mid-operation at cnt=5 of D=8 with a pending write
    wr(0, 8);
    wait_state(0, 8, 4);
    wr(0, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(10);

`ifdef CLKDIV_SYNC_EN
    // phase alignment of D=4 and D=6 channels
    wr(0, 4);
    wr(1, 6);
    run(9);
    sync_req = 1'b1;
    step();
    sync_req = 1'b0;
    run(26);
`endif

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      for (int c = 0; c < NCH; c++) en[c] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) begin
        wr_en = 1'b1;
        wr_ch = 2'($urandom_range(0, 3));
        wr_div = W'($urandom_range(0, 9));
      end else begin
        wr_en = 1'b0;
      end
`ifdef CLKDIV_SYNC_EN
      sync_req = ($urandom_range(0, 40) == 0);
`endif
      rst_n = ($urandom_range(0, 150) != 0);
      step();
    end
    wr_en = 1'b0; rst_n = 1'b1; sync_req = 1'b0;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Multi-channel, runtime-programmable successor to the fixed-divisor clock divider.
- Each of NCH channels divides clk_in by its own divisor and produces:
  - a near-50% divided square wave (clk_out), and
  - a one-cycle terminal-count strobe (tick), for use as a clock enable downstream.
- Divisors are written through a simple write port and take effect glitch-free at the channel's next terminal count.
- Sits between the board clock (50 MHz) and the KPN process modules that need slow timing.

Parameters:
- NCH, 4, number of independent channels (1..16).
- W, 27, counter and divisor width in bits; the maximum divisor is 2^W-1.
- DIV_RST, 50_000_000, divisor loaded into every channel at reset; must be >= 2.

Ports:
- clk_in  input  1  single system clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  NCH  per-channel run enable.
- wr_en  input  1  divisor write strobe.
- wr_ch  input  $clog2(NCH) (min 1)  channel index for the write.
- wr_div  input  W  new divisor value.
- clk_out  output  NCH  divided square wave per channel; registered.
- tick  output  NCH  one-cycle terminal-count strobe per channel; registered.
- upd_pend  output  NCH  high while a written divisor is not yet active.

Behaviour:
- Per-channel state: cnt[W], act_div[W] (active divisor), shd_div[W] (shadow divisor), pend.
- Reset (rst_n low at a clk_in edge):
  - cnt=0, act_div=shd_div=DIV_RST, pend=0.
  - clk_out=0, tick=0, upd_pend=0.
  - Overrides all other inputs, including a write in the same cycle.
- Write:
  - If wr_en=1 and wr_ch<NCH: shd_div[wr_ch]<=wr_div and pend[wr_ch]<=1 at the next edge.
  - If wr_ch>=NCH: the write is ignored.
  - A second write before the divisor loads overwrites the shadow; the last write wins.
- Counting (en=1, act_div>=2):
  - cnt runs 0..act_div-1 and then wraps to 0.
  - Terminal cycle is cnt==act_div-1.
  - At the terminal-cycle edge: cnt<=0, act_div<=shd_div, pend<=0.
- Outputs are flops whose value always equals a function of the current cnt and act_div:
  - clk_out = (cnt >= act_div>>1): high for ceil(D/2) cycles out of every D.
  - tick = (cnt == act_div-1).
  - There is no combinational path from inputs to outputs.
- act_div==1:
  - cnt held at 0, tick=1 every cycle, clk_out=1 constantly.
  - A pending shadow loads at the next edge.
- act_div==0:
  - Channel stopped: cnt=0, outputs 0.
  - A pending shadow loads at the next edge.
- en=0:
  - cnt<=0, clk_out<=0, tick<=0.
  - A pending shadow loads immediately (act_div<=shd_div, pend<=0).
- en rising:
  - First counted cycle has cnt=0.
  - For D=4 the first tick occurs 4 cycles after en is first sampled high.
- Write in the same cycle as a terminal count:
  - act_div loads the pre-write shadow value.
  - The new value lands in the shadow; pend stays 1 and the value loads at the following terminal count.
- Channels are fully independent; there is no cross-channel phase relationship unless CLKDIV_SYNC_EN is used.

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined:
  - Adds input sync_req (1 bit).
  - sync_req=1 at an edge forces cnt<=0 in every channel, loads act_div<=shd_div and clears pend.
  - Outputs in the following cycle reflect cnt=0, so all channels are phase-aligned.
  - Priority: rst_n > sync_req > write/count.
- Undefined:
  - The port is absent.
  - Behaviour is exactly as above.

Decomposition:
- Package clkdiv_pkg holds:
  - default constants NCH_DEF, W_DEF, DIV_RST_DEF;
  - the channel-index width constant/function (max(1,$clog2(NCH)));
  - typedef div_t (logic [W-1:0]).
- Sub-module clkdiv_channel:
  - one per channel, instantiated by a generate loop;
  - holds cnt, act_div, shd_div, pend, and the output flops;
  - the top decodes wr_ch into per-channel write strobes.

Test Plan:
- Reset/defaults: DIV_RST=4, en=1 after reset → clk_out pattern 0,0,1,1 repeating; tick high on every 4th cycle (cnt=3); upd_pend=0.
- Odd divisor: write D=5 to ch1 while ch1 is disabled, then enable → clk_out 0,0,1,1,1 repeating; tick period 5 cycles.
- Glitch-free update: ch0 running D=8; write D=3 when cnt=2 → ch0 finishes its 8-cycle period; upd_pend[0] high until the terminal edge; then a 3-cycle period; no short or long pulse.
- Boundaries:
  - D=1 → tick constantly 1, clk_out constantly 1.
  - D=0 → outputs 0.
  - wr_ch=NCH → no channel changes.
  - Write coincident with terminal count → old shadow applied, new value applied one period later.
- Reset mid-operation: rst_n low at cnt=5 of D=8 with a pending write → next cycle all outputs 0, act_div=DIV_RST, pend cleared.
- CLKDIV_SYNC_EN: channels with D=4 and D=6 running out of phase; pulse sync_req → both cnt=0 next cycle; ticks coincide every 12 cycles thereafter.
